// File: rtl/bitcount_pkg.sv
// Shared types and the round-robin arbitration helper for the bit-count scheduler.
package bitcount_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned REQ_MAX   = 4;
    localparam int unsigned PTR_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // First eligible index at or after rr_ptr, wrapping modulo n_req.
    function automatic pick_t rr_pick(
        input logic [REQ_MAX-1:0] eligible,
        input logic [PTR_W-1:0]   rr_ptr,
        input int unsigned        n_req
    );
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned k = 0; k < REQ_MAX; k++) begin
            j = (32'(rr_ptr) + k) % n_req;
            if (k < n_req && !p.found && eligible[PTR_W'(j)]) begin
                p.found = 1'b1;
                p.idx   = PTR_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bitcount_scheduler.sv
// Round-robin front end sharing one load/shift/increment bit-count datapath
// between N_REQ requesters; returns each popcount with a one-cycle pulse.
module bitcount_scheduler
    import bitcount_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1),
    parameter int unsigned N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   dp_load,
    output logic [WIDTH-1:0]       dp_load_val,
    output logic                   dp_rshift,
    output logic                   dp_incr,
    input  logic                   dp_zero,
    input  logic                   dp_a0,
    input  logic [CNT_W-1:0]       dp_result,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [CNT_W-1:0]       rsp_count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   served_q, served_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [N_REQ-1:0]   gnt_d, rsp_valid_d, owner_oh;
    logic               busy_d, load_d;
    logic [CNT_W-1:0]   rsp_count_d;
    logic [REQ_MAX-1:0] elig_ext;
    pick_t              pick;

    assign owner_oh    = N_REQ'(1) << owner_q;
    assign elig_ext    = REQ_MAX'(req & ~served_q);
    assign pick        = rr_pick(elig_ext, PTR_W'(rr_q), N_REQ);
    assign dp_load_val = operand_q;

    // Next-state and next-output decode; dp_rshift/dp_incr follow the live datapath flags.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        operand_d   = operand_q;
        served_d    = served_q & req;
        gnt_d       = '0;
        busy_d      = 1'b0;
        load_d      = 1'b0;
        rsp_valid_d = '0;
        rsp_count_d = '0;
        dp_rshift   = 1'b0;
        dp_incr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    owner_d = IDX_W'(pick.idx);
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (pick.idx == PTR_W'(i)) operand_d = a_in[i*WIDTH +: WIDTH];
                    end
                    gnt_d   = N_REQ'(1) << pick.idx;
                    busy_d  = 1'b1;
                    load_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gnt_d   = owner_oh;
                busy_d  = 1'b1;
                state_d = SCAN;
            end
            SCAN: begin
                gnt_d  = owner_oh;
                busy_d = 1'b1;
                if (dp_zero) begin
                    rsp_valid_d = owner_oh;
                    rsp_count_d = dp_result;
                    state_d     = DONE;
                end else begin
                    dp_rshift = 1'b1;
                    dp_incr   = dp_a0;
                end
            end
            DONE: begin
                // Holding req past the response blocks re-service until req drops.
                served_d[owner_q] = req[owner_q];
                rr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            served_q  <= '0;
            operand_q <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            dp_load   <= 1'b0;
            rsp_valid <= '0;
            rsp_count <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            served_q  <= served_d;
            operand_q <= operand_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            dp_load   <= load_d;
            rsp_valid <= rsp_valid_d;
            rsp_count <= rsp_count_d;
        end
    end

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Directed bench for bitcount_scheduler with a behavioural bit-count datapath partner.
module tb_bitcount_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] a_in;
    logic [1:0]  gnt;
    logic        busy;
    logic        dp_load;
    logic [7:0]  dp_load_val;
    logic        dp_rshift;
    logic        dp_incr;
    logic        dp_zero;
    logic        dp_a0;
    logic [3:0]  dp_result;
    logic [1:0]  rsp_valid;
    logic [3:0]  rsp_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bitcount_scheduler #(.WIDTH(8), .CNT_W(4), .N_REQ(2)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in),
        .gnt(gnt), .busy(busy),
        .dp_load(dp_load), .dp_load_val(dp_load_val),
        .dp_rshift(dp_rshift), .dp_incr(dp_incr),
        .dp_zero(dp_zero), .dp_a0(dp_a0), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_count(rsp_count)
    );

    // Bit-count datapath: shift register plus counter.
    logic [7:0] dp_reg;
    logic [3:0] dp_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_reg <= '0;
            dp_cnt <= '0;
        end else if (dp_load) begin
            dp_reg <= dp_load_val;
            dp_cnt <= '0;
        end else begin
            if (dp_rshift) dp_reg <= dp_reg >> 1;
            if (dp_incr)   dp_cnt <= dp_cnt + 4'd1;
        end
    end
    assign dp_zero   = (dp_reg == 8'h00);
    assign dp_a0     = dp_reg[0];
    assign dp_result = dp_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a response pulse or the cycle budget; cyc = -1 on timeout.
    task automatic wait_rsp(input int max, output int cyc, output logic [1:0] who,
                            output logic [3:0] cnt, output int shifts,
                            output logic [1:0] gnt1, output int overlap);
        bit done = 0;
        cyc = -1; who = '0; cnt = '0; shifts = 0; gnt1 = '0; overlap = 0;
        for (int c = 1; c <= max && !done; c++) begin
            tick();
            if (c == 1) gnt1 = gnt;
            if (dp_rshift) shifts++;
            if (dp_rshift && dp_load) overlap++;
            if (rsp_valid != 2'b00) begin
                cyc = c; who = rsp_valid; cnt = rsp_count; done = 1;
            end
        end
    endtask

    task automatic idle_watch(input int n, output int activity);
        activity = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (rsp_valid != 2'b00 || busy || gnt != 2'b00) activity++;
        end
    endtask

    task automatic test_reset();
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (rsp_valid !== 2'b00 || rsp_count !== 4'd0) begin miscompares++;
            $display("FAIL reset_rsp: got %b/%0d expected 00/0", rsp_valid, rsp_count); end
        vectors++; if (dp_load !== 1'b0 || dp_rshift !== 1'b0 || dp_incr !== 1'b0) begin miscompares++;
            $display("FAIL reset_dp: got load=%b rshift=%b incr=%b expected 0", dp_load, dp_rshift, dp_incr); end
    endtask

    task automatic test_single();
        int cyc, shifts, overlap; logic [1:0] who, g1; logic [3:0] cnt;
        req = 2'b01; a_in = {8'h00, 8'b0100_0100};
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (g1 !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b expected 01", g1); end
        vectors++; if (cyc != 10) begin miscompares++; $display("FAIL single_latency: got %0d expected 10", cyc); end
        vectors++; if (who !== 2'b01 || cnt !== 4'd2) begin miscompares++;
            $display("FAIL single_rsp: got %b/%0d expected 01/2", who, cnt); end
        vectors++; if (shifts != 7) begin miscompares++; $display("FAIL single_shifts: got %0d expected 7", shifts); end
        vectors++; if (overlap != 0) begin miscompares++; $display("FAIL single_load_shift: got %0d expected 0", overlap); end
        tick();
        vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++;
            $display("FAIL single_pulse_end: got rsp=%b busy=%b expected 00/0", rsp_valid, busy); end
        req = 2'b00; tick();
    endtask

    task automatic test_zero();
        int cyc, shifts, overlap; logic [1:0] who, g1; logic [3:0] cnt;
        req = 2'b10; a_in = {8'h00, 8'h00};
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (g1 !== 2'b10) begin miscompares++; $display("FAIL zero_gnt: got %b expected 10", g1); end
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL zero_latency: got %0d expected 3", cyc); end
        vectors++; if (who !== 2'b10 || cnt !== 4'd0) begin miscompares++;
            $display("FAIL zero_rsp: got %b/%0d expected 10/0", who, cnt); end
        vectors++; if (shifts != 0) begin miscompares++; $display("FAIL zero_shifts: got %0d expected 0", shifts); end
        req = 2'b00; tick();
    endtask

    task automatic test_both();
        int cyc, shifts, overlap, act; logic [1:0] who, g1; logic [3:0] cnt;
        reset = 1'b1; req = 2'b11; a_in = {8'h01, 8'hFF};
        tick();
        reset = 1'b0;
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 11 || who !== 2'b01 || cnt !== 4'd8) begin miscompares++;
            $display("FAIL both_first: got cyc=%0d %b/%0d expected 11 01/8", cyc, who, cnt); end
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 5 || who !== 2'b10 || cnt !== 4'd1) begin miscompares++;
            $display("FAIL both_second: got cyc=%0d %b/%0d expected 5 10/1", cyc, who, cnt); end
        idle_watch(15, act);
        vectors++; if (act != 0) begin miscompares++; $display("FAIL both_no_reserve: got %0d active cycles expected 0", act); end
        req = 2'b10; tick();
        req = 2'b11;
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 11 || who !== 2'b01 || cnt !== 4'd8) begin miscompares++;
            $display("FAIL both_reraise: got cyc=%0d %b/%0d expected 11 01/8", cyc, who, cnt); end
    endtask

    task automatic test_held();
        int cyc, shifts, overlap, act; logic [1:0] who, g1; logic [3:0] cnt;
        req = 2'b01;
        repeat (3) tick();
        req = 2'b11; a_in = {8'h03, 8'hFF};
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 5 || who !== 2'b10 || cnt !== 4'd2) begin miscompares++;
            $display("FAIL held_other: got cyc=%0d %b/%0d expected 5 10/2", cyc, who, cnt); end
        idle_watch(15, act);
        vectors++; if (act != 0) begin miscompares++; $display("FAIL held_no_reserve: got %0d active cycles expected 0", act); end
        req = 2'b00; tick(); tick();
    endtask

    task automatic test_reset_mid();
        int cyc, shifts, overlap; logic [1:0] who, g1; logic [3:0] cnt;
        req = 2'b01; a_in = {8'h00, 8'h80};
        repeat (4) tick();
        vectors++; if (busy !== 1'b1 || gnt !== 2'b01) begin miscompares++;
            $display("FAIL mid_busy: got busy=%b gnt=%b expected 1/01", busy, gnt); end
        reset = 1'b1;
        tick();
        vectors++; if (gnt !== 2'b00 || busy !== 1'b0 || rsp_valid !== 2'b00) begin miscompares++;
            $display("FAIL mid_reset: got gnt=%b busy=%b rsp=%b expected 00/0/00", gnt, busy, rsp_valid); end
        reset = 1'b0;
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 11 || who !== 2'b01 || cnt !== 4'd1) begin miscompares++;
            $display("FAIL mid_restart: got cyc=%0d %b/%0d expected 11 01/1", cyc, who, cnt); end
        req = 2'b00; tick();
    endtask

    task automatic test_operand_change();
        int cyc, shifts, overlap; logic [1:0] who, g1; logic [3:0] cnt;
        req = 2'b10; a_in = {8'h0F, 8'h00};
        repeat (3) tick();
        a_in = {8'hFF, 8'h00};
        wait_rsp(20, cyc, who, cnt, shifts, g1, overlap);
        vectors++; if (cyc != 4 || who !== 2'b10 || cnt !== 4'd4) begin miscompares++;
            $display("FAIL opchange: got cyc=%0d %b/%0d expected 4 10/4", cyc, who, cnt); end
        req = 2'b00; tick();
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; a_in = '0;
        tick(); tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_single();
        test_zero();
        test_both();
        test_held();
        test_reset_mid();
        test_operand_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
